// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a valid/ready byte stream into little-endian
// 32-bit words, writes them sequentially and holds the core while loading.
module imem_loader #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LEN_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len_words,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             we,
    output logic [31:0]      wa,
    output logic [31:0]      wd,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r, state_next_s;
    logic [1:0]         byte_idx_r, byte_idx_next_s;
    logic [IDX_W-1:0]   word_idx_r, word_idx_next_s;
    logic [LEN_W-1:0]   len_r, len_next_s;
    logic [31:0]        word_r, word_next_s;
    logic               error_r, error_next_s;
    logic               len_ok_s, last_word_s;

    logic               byte_ready_r, we_r, busy_r, cpu_hold_r, done_r;
    logic               byte_ready_next_s, we_next_s, busy_next_s, cpu_hold_next_s, done_next_s;
    logic [31:0]        wa_r, wd_r, wa_next_s, wd_next_s;

    assign len_ok_s    = (len_words != {LEN_W{1'b0}}) && (len_words <= LEN_W'(DEPTH_WORDS));
    assign last_word_s = (LEN_W'(word_idx_r) == (len_r - LEN_W'(1)));

    // State register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            byte_idx_r <= 2'd0;
            word_idx_r <= {IDX_W{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            word_r     <= 32'h0000_0000;
            error_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            byte_idx_r <= byte_idx_next_s;
            word_idx_r <= word_idx_next_s;
            len_r      <= len_next_s;
            word_r     <= word_next_s;
            error_r    <= error_next_s;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_next_s    = state_r;
        byte_idx_next_s = byte_idx_r;
        word_idx_next_s = word_idx_r;
        len_next_s      = len_r;
        word_next_s     = word_r;
        error_next_s    = error_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok_s) begin
                        len_next_s      = len_words;
                        error_next_s    = 1'b0;
                        byte_idx_next_s = 2'd0;
                        word_idx_next_s = {IDX_W{1'b0}};
                        word_next_s     = 32'h0000_0000;
                        state_next_s    = ST_RECV;
                    end else begin
                        error_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                // byte_ready is high throughout RECV, so valid alone completes a transfer
                if (byte_valid) begin
                    case (byte_idx_r)
                        2'd0:    word_next_s[7:0]   = byte_data;
                        2'd1:    word_next_s[15:8]  = byte_data;
                        2'd2:    word_next_s[23:16] = byte_data;
                        2'd3:    word_next_s[31:24] = byte_data;
                        default: word_next_s        = word_r;
                    endcase
                    byte_idx_next_s = byte_idx_r + 2'd1;
                    if (byte_idx_r == 2'd3) begin
                        state_next_s = ST_WRITE;
                    end else begin
                        state_next_s = ST_RECV;
                    end
                end else begin
                    state_next_s = ST_RECV;
                end
            end
            ST_WRITE: begin
                if (last_word_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    word_idx_next_s = word_idx_r + IDX_W'(1);
                    state_next_s    = ST_RECV;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every port leaves a flop
    always_comb begin
        byte_ready_next_s = (state_next_s == ST_RECV);
        we_next_s         = (state_next_s == ST_WRITE);
        busy_next_s       = (state_next_s != ST_IDLE);
        cpu_hold_next_s   = (state_next_s != ST_IDLE);
        done_next_s       = (state_next_s == ST_DONE);
        wa_next_s         = wa_r;
        wd_next_s         = wd_r;
        if (state_next_s == ST_WRITE) begin
            wa_next_s = BASE_ADDR + 32'({word_idx_next_s, 2'b00});
            wd_next_s = word_next_s;
        end else begin
            wa_next_s = wa_r;
            wd_next_s = wd_r;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_ready_r <= 1'b0;
            we_r         <= 1'b0;
            busy_r       <= 1'b0;
            cpu_hold_r   <= 1'b0;
            done_r       <= 1'b0;
            wa_r         <= 32'h0000_0000;
            wd_r         <= 32'h0000_0000;
        end else begin
            byte_ready_r <= byte_ready_next_s;
            we_r         <= we_next_s;
            busy_r       <= busy_next_s;
            cpu_hold_r   <= cpu_hold_next_s;
            done_r       <= done_next_s;
            wa_r         <= wa_next_s;
            wd_r         <= wd_next_s;
        end
    end

    assign byte_ready = byte_ready_r;
    assign we         = we_r;
    assign wa         = wa_r;
    assign wd         = wd_r;
    assign busy       = busy_r;
    assign cpu_hold   = cpu_hold_r;
    assign done       = done_r;
    assign error      = error_r;

endmodule
